// File: rtl/ls_pattern_gen.sv
// Burst stimulus source for the latch/shift-chain path: preamble, sync marker,
// pattern body and zero flush on D_OUT, plus a REF_DELAY-aligned copy on DATA_REF.
module ls_pattern_gen #(
  parameter int unsigned PRE_LEN   = 4,
  parameter int unsigned REF_DELAY = 16,
  parameter int unsigned FLUSH_LEN = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [1:0]  MODE,
  input  logic [15:0] NUM_BITS,
  output logic        D_OUT,
  output logic        DATA_REF,
  output logic        BUSY,
  output logic        DONE
);

  localparam int unsigned CNT_W       = 16;
  localparam int unsigned FLUSH_TOTAL = REF_DELAY + FLUSH_LEN;
  localparam logic [6:0]  LFSR_SEED   = 7'h7F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SYNC,
    S_BODY,
    S_FLUSH,
    S_FIN
  } state_t;

  state_t             state_q;
  logic               d_out_q;
  logic               busy_q;
  logic               done_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [6:0]         lfsr_q;
  logic               cb_q;
  logic [1:0]         mode_q;
  logic [CNT_W-1:0]   nbits_q;
  logic [REF_DELAY-1:0] dly_q;

  logic               body_bit_d;
  logic [6:0]         lfsr_d;

  // Pattern bit for the current body cycle and the PRBS7 (x^7+x^6+1) step.
  always_comb begin
    body_bit_d = 1'b0;
    lfsr_d     = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    case (mode_q)
      2'b00:   body_bit_d = 1'b0;
      2'b01:   body_bit_d = 1'b1;
      2'b10:   body_bit_d = cb_q;
      default: body_bit_d = lfsr_q[6];
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      d_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      cb_q    <= 1'b1;
      mode_q  <= 2'b00;
      nbits_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          d_out_q <= 1'b0;
          busy_q  <= 1'b0;
          if (START) begin
            mode_q  <= MODE;
            nbits_q <= NUM_BITS;
            lfsr_q  <= LFSR_SEED;
            cb_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_PRE;
          end
        end
        S_PRE: begin
          busy_q <= 1'b1;
          if (cnt_q == CNT_W'(PRE_LEN - 1)) begin
            d_out_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_SYNC;
          end else begin
            d_out_q <= 1'b0;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        S_SYNC: begin
          busy_q <= 1'b1;
          if (nbits_q == '0) begin
            d_out_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_FLUSH;
          end else begin
            d_out_q <= body_bit_d;
            lfsr_q  <= lfsr_d;
            cb_q    <= ~cb_q;
            cnt_q   <= CNT_W'(1);
            state_q <= S_BODY;
          end
        end
        S_BODY: begin
          busy_q <= 1'b1;
          // cnt_q holds the number of body bits already emitted
          if (cnt_q == nbits_q) begin
            d_out_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_FLUSH;
          end else begin
            d_out_q <= body_bit_d;
            lfsr_q  <= lfsr_d;
            cb_q    <= ~cb_q;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        S_FLUSH: begin
          d_out_q <= 1'b0;
          if (cnt_q == CNT_W'(FLUSH_TOTAL - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_FIN;
          end else begin
            busy_q  <= 1'b1;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        S_FIN: begin
          d_out_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          d_out_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Reference delay line runs every cycle so DATA_REF always trails D_OUT.
  if (REF_DELAY > 1) begin : g_dly_multi
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) dly_q <= '0;
      else     dly_q <= {dly_q[REF_DELAY-2:0], d_out_q};
    end
  end else begin : g_dly_single
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) dly_q <= '0;
      else     dly_q <= d_out_q;
    end
  end

  assign D_OUT    = d_out_q;
  assign DATA_REF = dly_q[REF_DELAY-1];
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_ls_pattern_gen.sv
// Scoreboard bench for ls_pattern_gen: a burst model queues per-cycle
// expectations on START acceptance; a monitor pops and compares every cycle.
module tb_ls_pattern_gen;

  localparam int unsigned PRE_LEN   = 4;
  localparam int unsigned REF_DELAY = 16;
  localparam int unsigned FLUSH_LEN = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [1:0]  MODE;
  logic [15:0] NUM_BITS;
  logic        D_OUT, DATA_REF, BUSY, DONE;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic d;
    logic busy;
    logic done;
  } exp_t;

  exp_t expq[$];
  logic hist[$];
  int   edge_n   = 0;
  int   fin_edge = -100;

  // downstream chain + error counter used for the integration check
  logic [REF_DELAY-1:0] chain_q;
  logic flip;
  logic ec_clr;
  logic ec_armed, ec_prev;
  int   ec_errs;
  logic Q;

  always #5 CLK = ~CLK;

  ls_pattern_gen #(
    .PRE_LEN  (PRE_LEN),
    .REF_DELAY(REF_DELAY),
    .FLUSH_LEN(FLUSH_LEN)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .MODE    (MODE),
    .NUM_BITS(NUM_BITS),
    .D_OUT   (D_OUT),
    .DATA_REF(DATA_REF),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Whole burst from the rules: zeros, marker, body, zeros; returns its length.
  function automatic int build_run(input logic [1:0] mode, input int nb);
    logic stream[$];
    logic prbs[$];
    for (int k = 0; k < int'(PRE_LEN); k++) stream.push_back(1'b0);
    stream.push_back(1'b1);
    for (int k = 0; k < nb; k++) begin
      if (k < 7) prbs.push_back(1'b1);
      else       prbs.push_back(prbs[k-7] ^ prbs[k-6]);
    end
    for (int k = 0; k < nb; k++) begin
      case (mode)
        2'b00:   stream.push_back(1'b0);
        2'b01:   stream.push_back(1'b1);
        2'b10:   stream.push_back((k % 2) == 0);
        default: stream.push_back(prbs[k]);
      endcase
    end
    for (int k = 0; k < int'(REF_DELAY + FLUSH_LEN); k++) stream.push_back(1'b0);
    for (int k = 0; k < stream.size(); k++)
      expq.push_back('{d: stream[k], busy: (k >= 1), done: 1'b0});
    expq.push_back('{d: 1'b0, busy: 1'b0, done: 1'b1});
    return stream.size();
  endfunction

  // Model: decides at each edge whether START is accepted.
  always @(posedge CLK) begin
    if (RST) begin
      expq.delete();
      fin_edge = -100;
    end else begin
      if (START && (edge_n >= fin_edge + 2))
        fin_edge = edge_n + build_run(MODE, int'(NUM_BITS));
      edge_n++;
    end
  end

  // Monitor: compares every cycle against the queued expectation.
  initial begin
    logic rst_edge;
    exp_t e;
    for (int i = 0; i < int'(REF_DELAY); i++) hist.push_back(1'b0);
    forever begin
      @(posedge CLK);
      rst_edge = RST;
      @(negedge CLK);
      if (rst_edge || RST) begin
        check_bit("rst_d_out", D_OUT, 1'b0);
        check_bit("rst_data_ref", DATA_REF, 1'b0);
        check_bit("rst_busy", BUSY, 1'b0);
        check_bit("rst_done", DONE, 1'b0);
        hist.delete();
        for (int i = 0; i < int'(REF_DELAY); i++) hist.push_back(1'b0);
      end else begin
        e = (expq.size() > 0) ? expq.pop_front() : exp_t'(3'b000);
        check_bit("d_out", D_OUT, e.d);
        check_bit("busy", BUSY, e.busy);
        check_bit("done", DONE, e.done);
        check_bit("data_ref", DATA_REF, hist[0]);
        void'(hist.pop_front());
        hist.push_back(e.d);
      end
    end
  end

  assign Q = chain_q[REF_DELAY-1] ^ flip;

  always @(posedge CLK) begin
    if (RST) chain_q <= '0;
    else     chain_q <= {chain_q[REF_DELAY-2:0], D_OUT};
  end

  always @(posedge CLK) begin
    if (ec_clr) begin
      ec_armed <= 1'b0;
      ec_prev  <= 1'b0;
      ec_errs  <= 0;
    end else begin
      ec_prev <= DATA_REF;
      if (!ec_armed && DATA_REF && !ec_prev) ec_armed <= 1'b1;
      if ((ec_armed || (DATA_REF && !ec_prev)) && (Q != DATA_REF)) ec_errs <= ec_errs + 1;
    end
  end

  task automatic start_run(input logic [1:0] m, input logic [15:0] nb);
    @(posedge CLK); #2;
    START = 1'b1; MODE = m; NUM_BITS = nb;
    @(posedge CLK); #2;
    START = 1'b0; MODE = ~m; NUM_BITS = 16'($urandom);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge CLK);
      if (DONE) seen = 1'b1;
    end
    check_bit(name, seen, 1'b1);
  endtask

  initial begin
    int c, busy_c;
    bit seen;
    RST = 1'b1; START = 1'b0; MODE = 2'b00; NUM_BITS = 16'd0;
    flip = 1'b0; ec_clr = 1'b1;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b0;
    repeat (2) @(posedge CLK);

    // checkerboard, 8 bits: DONE 37 edges after START, BUSY 36 cycles
    start_run(2'b10, 16'd8);
    c = 0; busy_c = 0; seen = 1'b0;
    while (!seen && c < 200) begin
      @(negedge CLK);
      c++;
      if (BUSY) busy_c++;
      if (DONE) seen = 1'b1;
    end
    check_bit("cb_done_seen", seen, 1'b1);
    check_int("cb_done_latency", c - 1, 37);
    check_int("cb_busy_cycles", busy_c, 36);
    repeat (3) @(posedge CLK);

    start_run(2'b11, 16'd130);
    wait_done("prbs130_done");
    repeat (3) @(posedge CLK);

    start_run(2'b01, 16'd0);
    wait_done("nb0_done");
    repeat (3) @(posedge CLK);

    // re-pulse during BODY is ignored; restart right after DONE
    start_run(2'b10, 16'd20);
    repeat (8) @(posedge CLK);
    #2 START = 1'b1; MODE = 2'b11;
    @(posedge CLK); #2 START = 1'b0;
    wait_done("repulse_done");
    @(posedge CLK); #2 START = 1'b1; MODE = 2'b01; NUM_BITS = 16'd5;
    @(posedge CLK); #2 START = 1'b0;
    @(negedge CLK); @(negedge CLK);
    check_bit("restart_busy", BUSY, 1'b1);
    wait_done("restart_done");
    repeat (3) @(posedge CLK);

    // async reset mid-BODY, then PRBS restarts from the seed
    start_run(2'b11, 16'd50);
    repeat (12) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check_bit("async_busy", BUSY, 1'b0);
    check_bit("async_d_out", D_OUT, 1'b0);
    check_bit("async_done", DONE, 1'b0);
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    start_run(2'b11, 16'd10);
    wait_done("post_rst_done");
    repeat (3) @(posedge CLK);

    // integration with chain and error counter
    @(posedge CLK); #2 ec_clr = 1'b0;
    start_run(2'b11, 16'd1000);
    wait_done("int_clean_done");
    repeat (2) @(posedge CLK);
    check_int("int_clean_errs", ec_errs, 0);
    #2 ec_clr = 1'b1;
    @(posedge CLK); #2 ec_clr = 1'b0;
    start_run(2'b11, 16'd1000);
    repeat (100) @(posedge CLK);
    #2 flip = 1'b1;
    @(posedge CLK); #2 flip = 1'b0;
    wait_done("int_flip_done");
    repeat (2) @(posedge CLK);
    check_int("int_flip_errs", ec_errs, 1);

    // random START pulses and inputs
    repeat (3000) begin
      @(posedge CLK); #2;
      START    = ($urandom_range(0, 6) == 0);
      MODE     = 2'($urandom);
      NUM_BITS = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(120, 140))
                                             : 16'($urandom_range(0, 24));
    end
    START = 1'b0;
    for (int i = 0; i < 400 && expq.size() > 0; i++) @(posedge CLK);
    @(negedge CLK);
    check_int("queue_drained", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
